// File: rtl/ysyx_22051013_pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: memory FSM states, forwarding
// select codes and the reset level.
package ysyx_22051013_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_LS = 2'b10;
    localparam logic [1:0] FWD_WB = 2'b11;

    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/ysyx_22051013_pipe_ctrl_fwd_sel.sv
// Per-source forwarding priority mux: the youngest in-flight writer of the
// source register wins; x0 never forwards.
module ysyx_22051013_fwd_sel
    import ysyx_22051013_pipe_ctrl_pkg::*;
(
    input  logic [4:0] src_addr,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_rd_ena,
    input  logic       ex_is_load,
    input  logic [4:0] ls_rd_addr,
    input  logic       ls_rd_ena,
    input  logic [4:0] wb_rd_addr,
    input  logic       wb_rd_ena,
    output logic [1:0] sel
);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else chain can infer a latch.
    always_comb begin
        sel = FWD_RF;
        if (src_addr == 5'd0) begin
            sel = FWD_RF;
        end else if (ex_rd_ena && (ex_rd_addr == src_addr)) begin
            // A load in EX has no data yet; the load-use stall waits for LS.
            sel = ex_is_load ? FWD_RF : FWD_EX;
        end else if (ls_rd_ena && (ls_rd_addr == src_addr)) begin
            sel = FWD_LS;
        end else if (wb_rd_ena && (wb_rd_addr == src_addr)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ysyx_22051013_pipe_ctrl.sv
// Central stall/flush and forwarding controller of the 5-stage pipeline,
// including the LS data-memory handshake FSM with a deadlock timeout.
module ysyx_22051013_pipe_ctrl
    import ysyx_22051013_pipe_ctrl_pkg::*;
#(
    parameter int TMO_W  = 8,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [4:0]        ex_rd_addr,
    input  logic              ex_rd_ena,
    input  logic              ex_is_load,
    input  logic [4:0]        ls_rd_addr_forward,
    input  logic              ls_rd_ena,
    input  logic [4:0]        wb_rd_addr,
    input  logic              wb_rd_ena,
    input  logic              ex_redirect,
    input  logic              if_busy,
    input  logic              ls_mem_op,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              idex_stall,
    output logic              exls_stall,
    output logic              lswb_stall,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_rs1_sel,
    output logic [1:0]        fwd_rs2_sel,
    output logic              mem_timeout,
    output logic [PERF_W-1:0] stall_cycles
);

    // Fires on the cycle the counter would step into all-ones.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    mem_state_e        state, state_nxt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              mem_busy;
    logic              tmo_fire;
    logic              load_use;
    logic              in_reset;

    assign in_reset = (rst == RST_ACTIVE);
    assign mem_busy = (state == MEM_REQ) || (state == MEM_WAIT);
    assign tmo_fire = mem_busy && (tmo_cnt == TMO_LAST);
    assign mem_req_valid = (state == MEM_REQ);

    assign load_use = ex_is_load && ex_rd_ena && (ex_rd_addr != 5'd0) &&
                      ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                       (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

    always_comb begin
        state_nxt = state;
        unique case (state)
            MEM_IDLE: if (ls_mem_op) state_nxt = MEM_REQ;
            MEM_REQ:  if (mem_req_ready) state_nxt = mem_resp_valid ? MEM_DONE : MEM_WAIT;
            MEM_WAIT: if (mem_resp_valid) state_nxt = MEM_DONE;
            MEM_DONE: state_nxt = ls_mem_op ? MEM_REQ : MEM_IDLE;
            default:  state_nxt = MEM_IDLE;
        endcase
        if (tmo_fire) state_nxt = MEM_DONE;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering in simulation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= MEM_IDLE;
            tmo_cnt      <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= mem_busy ? tmo_cnt + TMO_W'(1) : '0;
            if (tmo_fire) mem_timeout <= 1'b1;
            if (pc_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

    // A redirect or load-use seen while memory is busy stays on the inputs
    // because EX is frozen, so it resolves naturally once mem_busy drops.
    always_comb begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        idex_stall = 1'b0;
        exls_stall = 1'b0;
        lswb_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (in_reset) begin
            pc_stall = 1'b0;
        end else if (mem_busy) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            exls_stall = 1'b1;
            lswb_stall = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end else if (if_busy) begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
        end
    end

    ysyx_22051013_fwd_sel u_fwd_rs1 (
        .src_addr   (id_rs1_addr),
        .ex_rd_addr (ex_rd_addr),
        .ex_rd_ena  (ex_rd_ena),
        .ex_is_load (ex_is_load),
        .ls_rd_addr (ls_rd_addr_forward),
        .ls_rd_ena  (ls_rd_ena),
        .wb_rd_addr (wb_rd_addr),
        .wb_rd_ena  (wb_rd_ena),
        .sel        (fwd_rs1_sel)
    );

    ysyx_22051013_fwd_sel u_fwd_rs2 (
        .src_addr   (id_rs2_addr),
        .ex_rd_addr (ex_rd_addr),
        .ex_rd_ena  (ex_rd_ena),
        .ex_is_load (ex_is_load),
        .ls_rd_addr (ls_rd_addr_forward),
        .ls_rd_ena  (ls_rd_ena),
        .wb_rd_addr (wb_rd_addr),
        .wb_rd_ena  (wb_rd_ena),
        .sel        (fwd_rs2_sel)
    );

endmodule

// File: tb/tb_ysyx_22051013_pipe_ctrl.sv
// Directed self-checking bench for the pipeline controller (timeout width 3).
module tb_ysyx_22051013_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_addr, id_rs2_addr;
    logic        id_rs1_used, id_rs2_used;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_ena, ex_is_load;
    logic [4:0]  ls_rd_addr_forward;
    logic        ls_rd_ena;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_ena;
    logic        ex_redirect, if_busy, ls_mem_op;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic        pc_stall, ifid_stall, idex_stall, exls_stall, lswb_stall;
    logic        ifid_flush, idex_flush;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic        mem_timeout;
    logic [31:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    // {pc, ifid, idex, exls, lswb stalls, ifid flush, idex flush}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_ALL  = 7'b1111100;
    localparam logic [6:0] C_REDR = 7'b0000011;
    localparam logic [6:0] C_LU   = 7'b1100001;
    localparam logic [6:0] C_IFB  = 7'b1000010;

    logic [6:0] ctl;
    assign ctl = {pc_stall, ifid_stall, idex_stall, exls_stall, lswb_stall, ifid_flush, idex_flush};

    always #5 clk = ~clk;

    ysyx_22051013_pipe_ctrl #(.TMO_W(3), .PERF_W(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .id_rs1_addr        (id_rs1_addr),
        .id_rs2_addr        (id_rs2_addr),
        .id_rs1_used        (id_rs1_used),
        .id_rs2_used        (id_rs2_used),
        .ex_rd_addr         (ex_rd_addr),
        .ex_rd_ena          (ex_rd_ena),
        .ex_is_load         (ex_is_load),
        .ls_rd_addr_forward (ls_rd_addr_forward),
        .ls_rd_ena          (ls_rd_ena),
        .wb_rd_addr         (wb_rd_addr),
        .wb_rd_ena          (wb_rd_ena),
        .ex_redirect        (ex_redirect),
        .if_busy            (if_busy),
        .ls_mem_op          (ls_mem_op),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_resp_valid     (mem_resp_valid),
        .pc_stall           (pc_stall),
        .ifid_stall         (ifid_stall),
        .idex_stall         (idex_stall),
        .exls_stall         (exls_stall),
        .lswb_stall         (lswb_stall),
        .ifid_flush         (ifid_flush),
        .idex_flush         (idex_flush),
        .fwd_rs1_sel        (fwd_rs1_sel),
        .fwd_rs2_sel        (fwd_rs2_sel),
        .mem_timeout        (mem_timeout),
        .stall_cycles       (stall_cycles)
    );

    task automatic clear_inputs();
        id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rd_addr = '0; ex_rd_ena = 0; ex_is_load = 0;
        ls_rd_addr_forward = '0; ls_rd_ena = 0; wb_rd_addr = '0; wb_rd_ena = 0;
        ex_redirect = 0; if_busy = 0; ls_mem_op = 0;
        mem_req_ready = 0; mem_resp_valid = 0;
    endtask

    // Leaves the bench just after a negedge, ready to drive cycle 0.
    task automatic reset_dut();
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_dest(input logic [4:0] exr, input logic exe, input logic exl,
                            input logic [4:0] lsr, input logic lse,
                            input logic [4:0] wbr, input logic wbe);
        ex_rd_addr = exr; ex_rd_ena = exe; ex_is_load = exl;
        ls_rd_addr_forward = lsr; ls_rd_ena = lse;
        wb_rd_addr = wbr; wb_rd_ena = wbe;
    endtask

    task automatic test_reset();
        clear_inputs();
        if_busy = 1'b1;
        #1;
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE); end
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", mem_req_valid); end
        n_cmp++; if (mem_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_tmo: got %b want 0", mem_timeout); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_perf: got %0d want 0", stall_cycles); end
        @(negedge clk);
        rst = 1'b1;
        if_busy = 1'b0;
    endtask

    task automatic test_mem_load();
        logic [3:0] stim [0:6];   // {ls_mem_op, ready, resp, exp_req_valid}
        logic [6:0] exp_ctl [0:6];
        stim    = '{4'b1000, 4'b1101, 4'b1000, 4'b1000, 4'b1010, 4'b0000, 4'b0000};
        exp_ctl = '{C_NONE, C_ALL, C_ALL, C_ALL, C_ALL, C_NONE, C_NONE};
        reset_dut();
        for (int c = 0; c < 7; c++) begin
            ls_mem_op = stim[c][3]; mem_req_ready = stim[c][2]; mem_resp_valid = stim[c][1];
            #1;
            n_cmp++; if (ctl !== exp_ctl[c]) begin n_bad++; $display("FAIL load_ctl c%0d: got %b want %b", c, ctl, exp_ctl[c]); end
            n_cmp++; if (mem_req_valid !== stim[c][0]) begin n_bad++; $display("FAIL load_req c%0d: got %b want %b", c, mem_req_valid, stim[c][0]); end
            @(negedge clk);
        end
        clear_inputs();
        #1;
        n_cmp++; if (stall_cycles !== 32'd4) begin n_bad++; $display("FAIL load_perf: got %0d want 4", stall_cycles); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        reset_dut();
        ls_mem_op = 1'b1;
        #1;
        @(negedge clk);
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        #1;
        n_cmp++; if (ctl !== C_ALL || mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_req: got %b/%b want %b/1", ctl, mem_req_valid, C_ALL); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++; if (ctl !== C_NONE || mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_done: got %b/%b want %b/0", ctl, mem_req_valid, C_NONE); end
        @(negedge clk);
        mem_resp_valid = 1'b1;
        #1;
        n_cmp++; if (ctl !== C_NONE || mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b/%b want %b/0", ctl, mem_req_valid, C_NONE); end
        n_cmp++; if (stall_cycles !== 32'd1) begin n_bad++; $display("FAIL b2b_perf: got %0d want 1", stall_cycles); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        reset_dut();
        ls_mem_op = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        n_cmp++; if (ctl !== C_ALL) begin n_bad++; $display("FAIL rstw_pre: got %b want %b", ctl, C_ALL); end
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (ctl !== C_NONE || mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rstw_async: got %b/%b want %b/0", ctl, mem_req_valid, C_NONE); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL rstw_perf: got %0d want 0", stall_cycles); end
        @(negedge clk);
        rst = 1'b1;
        ls_mem_op = 1'b0;
        mem_resp_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (ctl !== C_NONE || mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rstw_idle c%0d: got %b/%b want %b/0", c, ctl, mem_req_valid, C_NONE); end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        reset_dut();
        ls_mem_op = 1'b1;
        @(negedge clk);
        ls_mem_op = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            #1;
            n_cmp++; if (ctl !== C_ALL || mem_req_valid !== 1'b1 || mem_timeout !== 1'b0) begin
                n_bad++; $display("FAIL tmo_wait c%0d: got %b/%b/%b want %b/1/0", c, ctl, mem_req_valid, mem_timeout, C_ALL);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (mem_timeout !== 1'b1 || ctl !== C_NONE) begin n_bad++; $display("FAIL tmo_done: got %b/%b want 1/%b", mem_timeout, ctl, C_NONE); end
        n_cmp++; if (stall_cycles !== 32'd7) begin n_bad++; $display("FAIL tmo_perf: got %0d want 7", stall_cycles); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (mem_timeout !== 1'b1 || ctl !== C_NONE || mem_req_valid !== 1'b0) begin
                n_bad++; $display("FAIL tmo_sticky c%0d: got %b/%b/%b want 1/%b/0", c, mem_timeout, ctl, mem_req_valid, C_NONE);
            end
        end
        @(negedge clk);
        reset_dut();
        #1;
        n_cmp++; if (mem_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_clear: got %b want 0", mem_timeout); end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        reset_dut();
        id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
        set_dest(5'd5, 1, 1, 5'd0, 0, 5'd0, 0);
        #1;
        n_cmp++; if (ctl !== C_LU) begin n_bad++; $display("FAIL lu_stall: got %b want %b", ctl, C_LU); end
        n_cmp++; if (fwd_rs1_sel !== 2'b00) begin n_bad++; $display("FAIL lu_fwd_ex: got %b want 00", fwd_rs1_sel); end
        @(negedge clk);
        set_dest(5'd0, 0, 0, 5'd5, 1, 5'd0, 0);
        #1;
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL lu_release: got %b want %b", ctl, C_NONE); end
        n_cmp++; if (fwd_rs1_sel !== 2'b10) begin n_bad++; $display("FAIL lu_fwd_ls: got %b want 10", fwd_rs1_sel); end
        @(negedge clk);
        id_rs1_used = 1'b0; id_rs2_addr = 5'd5; id_rs2_used = 1'b0;
        set_dest(5'd5, 1, 1, 5'd0, 0, 5'd0, 0);
        #1;
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL lu_unused: got %b want %b", ctl, C_NONE); end
        id_rs2_used = 1'b1;
        #1;
        n_cmp++; if (ctl !== C_LU) begin n_bad++; $display("FAIL lu_rs2: got %b want %b", ctl, C_LU); end
        id_rs2_addr = 5'd0; id_rs1_addr = 5'd0; id_rs1_used = 1'b1;
        set_dest(5'd0, 1, 1, 5'd0, 0, 5'd0, 0);
        #1;
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL lu_x0: got %b want %b", ctl, C_NONE); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_redirect();
        reset_dut();
        id_rs1_addr = 5'd3; id_rs1_used = 1'b1;
        set_dest(5'd3, 1, 1, 5'd0, 0, 5'd0, 0);
        if_busy = 1'b1; ex_redirect = 1'b1;
        #1;
        n_cmp++; if (ctl !== C_REDR) begin n_bad++; $display("FAIL redir_prio: got %b want %b", ctl, C_REDR); end
        ex_redirect = 1'b0; set_dest(5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
        #1;
        n_cmp++; if (ctl !== C_IFB) begin n_bad++; $display("FAIL if_busy: got %b want %b", ctl, C_IFB); end
        @(negedge clk);
        clear_inputs();
        // Redirect arriving during a memory access waits for the access to end.
        ls_mem_op = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b1; ex_redirect = 1'b1; if_busy = 1'b1;
        #1;
        n_cmp++; if (ctl !== C_ALL) begin n_bad++; $display("FAIL redir_busy_req: got %b want %b", ctl, C_ALL); end
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        #1;
        n_cmp++; if (ctl !== C_ALL) begin n_bad++; $display("FAIL redir_busy_wait: got %b want %b", ctl, C_ALL); end
        @(negedge clk);
        mem_resp_valid = 1'b0; ls_mem_op = 1'b0;
        #1;
        n_cmp++; if (ctl !== C_REDR) begin n_bad++; $display("FAIL redir_held: got %b want %b", ctl, C_REDR); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_forward();
        reset_dut();
        id_rs1_addr = 5'd7; id_rs2_addr = 5'd9;
        set_dest(5'd7, 1, 0, 5'd7, 1, 5'd7, 1);
        #1;
        n_cmp++; if (fwd_rs1_sel !== 2'b01) begin n_bad++; $display("FAIL fwd_all_ex: got %b want 01", fwd_rs1_sel); end
        n_cmp++; if (fwd_rs2_sel !== 2'b00) begin n_bad++; $display("FAIL fwd_rs2_none: got %b want 00", fwd_rs2_sel); end
        set_dest(5'd7, 0, 0, 5'd7, 1, 5'd9, 1);
        #1;
        n_cmp++; if (fwd_rs1_sel !== 2'b10) begin n_bad++; $display("FAIL fwd_ls: got %b want 10", fwd_rs1_sel); end
        n_cmp++; if (fwd_rs2_sel !== 2'b11) begin n_bad++; $display("FAIL fwd_rs2_wb: got %b want 11", fwd_rs2_sel); end
        set_dest(5'd7, 1, 0, 5'd6, 1, 5'd7, 1);
        id_rs2_addr = 5'd6;
        #1;
        n_cmp++; if (fwd_rs2_sel !== 2'b10) begin n_bad++; $display("FAIL fwd_rs2_ls: got %b want 10", fwd_rs2_sel); end
        set_dest(5'd1, 1, 0, 5'd7, 0, 5'd7, 1);
        #1;
        n_cmp++; if (fwd_rs1_sel !== 2'b11) begin n_bad++; $display("FAIL fwd_wb: got %b want 11", fwd_rs1_sel); end
        set_dest(5'd7, 1, 1, 5'd7, 1, 5'd7, 1);
        #1;
        n_cmp++; if (fwd_rs1_sel !== 2'b00) begin n_bad++; $display("FAIL fwd_ex_load: got %b want 00", fwd_rs1_sel); end
        id_rs1_addr = 5'd0;
        set_dest(5'd0, 1, 0, 5'd0, 1, 5'd0, 1);
        #1;
        n_cmp++; if (fwd_rs1_sel !== 2'b00) begin n_bad++; $display("FAIL fwd_x0: got %b want 00", fwd_rs1_sel); end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_mem_load();
        test_back_to_back();
        test_reset_mid_wait();
        test_timeout();
        test_load_use();
        test_redirect();
        test_forward();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22051013_pipe_ctrl.md
Name: ysyx_22051013_pipe_ctrl

Overview:
- Central stall/flush and forwarding controller of the 5-stage pipeline. It is the source end of the per-register stall/flush controls (pc, if/id, id/ex, ex/ls, ls/wb) and the consumer of the ls/wb forwarding taps.
- Owns the LS-stage data-memory request handshake FSM. Resolves load-use, memory-wait, fetch-wait and branch-redirect hazards into one consistent stall/flush vector each cycle.
- Generates rs1/rs2 forwarding selects for the ID stage.

Parameters:
- TMO_W, 8: width of the memory-wait timeout counter. Timeout fires at 2^TMO_W-1 wait cycles.
- PERF_W, 32: width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- id_rs1_addr, id_rs2_addr  in  5  ID source registers
- id_rs1_used, id_rs2_used  in  1  source actually read
- ex_rd_addr  in  5; ex_rd_ena  in  1; ex_is_load  in  1  EX destination info
- ls_rd_addr_forward  in  5; ls_rd_ena  in  1  LS destination tap
- wb_rd_addr  in  5; wb_rd_ena  in  1  WB destination
- ex_redirect  in  1  taken branch/jump resolved in EX
- if_busy  in  1  fetch response not yet available
- ls_mem_op  in  1  LS holds a load/store
- mem_req_valid  out  1; mem_req_ready  in  1; mem_resp_valid  in  1  data-memory handshake
- pc_stall, ifid_stall, idex_stall, exls_stall, lswb_stall  out  1 each
- ifid_flush, idex_flush  out  1 each
- fwd_rs1_sel, fwd_rs2_sel  out  2  00 regfile, 01 EX result, 10 LS data, 11 WB data
- mem_timeout  out  1  sticky error flag
- stall_cycles  out  PERF_W  saturating count of cycles with pc_stall=1

Behaviour:
- Reset (rst=0, async):
  - FSM returns to IDLE.
  - All stall/flush outputs are 0; mem_req_valid=0; mem_timeout=0; stall_cycles=0.
  - Timeout counter is 0.
  - Reset mid-handshake abandons the request; memory responses are ignored until the next request.
- Memory FSM:
  - IDLE: when ls_mem_op=1, go to REQ.
  - REQ: mem_req_valid=1. When mem_req_ready=1, go to WAIT. If mem_resp_valid=1 in the same cycle as mem_req_ready=1, go directly to DONE.
  - WAIT: mem_req_valid=0. When mem_resp_valid=1, go to DONE.
  - DONE: single cycle, no stall. The LS instruction advances. Go to IDLE, or to REQ if the next ls_mem_op is already 1 after the advance.
  - mem_busy = (state==REQ or state==WAIT).
  - ls_mem_op=1 while in IDLE costs at least one stall cycle, because REQ is entered on the next edge.
- Timeout:
  - The counter increments each cycle in REQ/WAIT and clears in IDLE/DONE.
  - When it reaches all-ones: set mem_timeout (sticky until reset) and force the FSM to DONE so the pipeline does not deadlock.
- Priority, evaluated combinationally each cycle:
  1. mem_busy: all five stall outputs =1; flushes =0. A redirect or load-use present during this time is held and acts once mem_busy drops.
  2. ex_redirect: ifid_flush=1, idex_flush=1, no stalls. Overrides load-use and if_busy, since the ID/IF contents are wrong-path.
  3. load-use: ex_is_load & ex_rd_ena & ex_rd_addr!=0 & ((id_rs1_used & rs1==ex_rd) | (id_rs2_used & rs2==ex_rd)). Drives pc_stall=1, ifid_stall=1, idex_flush=1 for exactly one cycle, because the load then leaves EX.
  4. if_busy: pc_stall=1, ifid_flush=1 (bubble into ID); downstream stages keep flowing.
- Forwarding select, per source, combinational:
  - Address 0 always gives 00.
  - Otherwise the youngest match wins: EX (non-load, ex_rd_ena), then LS, then WB, else 00.
  - An EX load match gives 00; the load-use stall covers that case.
- stall_cycles increments on each clk edge with pc_stall=1 and saturates at all-ones.
- No combinational path from mem_resp_valid to mem_req_valid.

Decomposition:
- Shared define.v gains: FSM state encodings (IDLE=2'd0, REQ=1, WAIT=2, DONE=3), forwarding select codes, and the active-low reset level.
- One natural sub-module: ysyx_22051013_fwd_sel, the combinational per-source forwarding priority mux, instantiated twice.

Test Plan:
- Reset mid-WAIT: drive rst=0 asynchronously. All outputs go 0 immediately; a later mem_resp_valid has no effect and the FSM stays IDLE.
- Load with mem_req_ready=1 at cycle 1 and mem_resp_valid at cycle 4: all stalls high for cycles 1-4 (REQ, then WAIT through the response), DONE at cycle 5; stall_cycles=4.
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1. Exactly one cycle of pc_stall=ifid_stall=idex_flush=1; the next cycle fwd_rs1_sel=10.
- ex_redirect with a simultaneous load-use and if_busy: only ifid_flush=idex_flush=1; no stall.
- rs1=7 matching EX (non-load), LS and WB together gives fwd_rs1_sel=01. rs1=0 with all matching gives 00.
- TMO_W=3, no mem_resp_valid: after 7 wait cycles mem_timeout=1 and stays 1; the FSM passes DONE, then IDLE.
